// File: rtl/pulse_edge_sequencer.sv
//------------------------------------------------------------------------------
// pulse_edge_sequencer
//
// Steps an LED pattern forward each time the upstream tick level (iPulse)
// changes in the selected direction. A sequence is started by iStart. It ends
// after pStepNum steps, or it wraps back to step 0 when pLoop is set. iStop
// aborts the sequence.
//
// Parameters
//   pLedWidth : LED output width N (2..32)
//   pStepNum  : steps per sequence (1..255)
//   pEdgeSel  : 0 rising, 1 falling, 2/3 both edges of iPulse advance a step
//   pLoop     : 1 wraps to step 0 after the last step instead of stopping
//
// Ports
//   iSysClk : system clock; all logic runs on its rising edge
//   iSysRst : asynchronous active-low reset
//   iPulse  : tick level from the pulse generator (same clock domain)
//   iStart  : start request; accepted only while idle and iStop is low
//   iStop   : abort request; returns to idle with the LEDs cleared
//   iMode   : pattern select (0 walk, 1 bounce, 2 fill, 3 blink), latched at start
//   oLed    : registered LED pattern
//   oEdge   : one-cycle strobe for each qualified iPulse edge while running
//   oBusy   : high while a sequence is running
//   oDone   : one-cycle strobe when a sequence completes
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module pulse_edge_sequencer #(
    parameter int unsigned pLedWidth = 8,
    parameter int unsigned pStepNum  = 16,
    parameter logic [1:0]  pEdgeSel  = 2'd2,
    parameter logic        pLoop     = 1'b0
) (
    input  logic                 iSysClk,
    input  logic                 iSysRst,
    input  logic                 iPulse,
    input  logic                 iStart,
    input  logic                 iStop,
    input  logic [1:0]           iMode,
    output logic [pLedWidth-1:0] oLed,
    output logic                 oEdge,
    output logic                 oBusy,
    output logic                 oDone
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [7:0]           cLastStep     = 8'(pStepNum - 1);
    localparam int unsigned          cBouncePeriod = 2 * pLedWidth - 2;
    localparam logic [pLedWidth-1:0] cOne          = {{(pLedWidth-1){1'b0}}, 1'b1};
    localparam logic [pLedWidth-1:0] cAll          = {pLedWidth{1'b1}};

    state_t     rState;
    logic [7:0] rStep;
    logic [1:0] rMode;
    logic       rPulse0;
    logic       rPulse1;

    logic       pulseRise;
    logic       pulseFall;
    logic       qualEdge;

    // LED pattern for a given mode and step. Every shift amount is reduced
    // below pLedWidth first, so no shift ever runs off the end of the vector.
    function automatic logic [pLedWidth-1:0] ledPattern(input logic [1:0] mode,
                                                        input logic [7:0] step);
        int unsigned          stepMod;
        int unsigned          bouncePhase;
        int unsigned          bouncePos;
        logic [pLedWidth-1:0] pat;
        stepMod     = 32'(step) % pLedWidth;
        bouncePhase = 32'(step) % cBouncePeriod;
        bouncePos   = (bouncePhase < pLedWidth) ? bouncePhase
                                                : (cBouncePeriod - bouncePhase);
        pat         = '0;
        case (mode)
            2'd0:    pat = cOne << stepMod;
            2'd1:    pat = cOne << bouncePos;
            // Bits [stepMod:0] set: drop the unwanted high ones from an all-ones word.
            2'd2:    pat = cAll >> (pLedWidth - 1 - stepMod);
            default: pat = step[0] ? '0 : cAll;
        endcase
        return pat;
    endfunction

    // rPulse0 is the newest sample of iPulse and rPulse1 the one before, so an
    // edge is visible one clock after iPulse moves and acted on at the next.
    assign pulseRise = rPulse0 & ~rPulse1;
    assign pulseFall = ~rPulse0 & rPulse1;

    always_comb begin
        case (pEdgeSel)
            2'd0:    qualEdge = pulseRise;
            2'd1:    qualEdge = pulseFall;
            default: qualEdge = pulseRise | pulseFall;
        endcase
    end

    always_ff @(posedge iSysClk or negedge iSysRst) begin
        if (!iSysRst) begin
            rState  <= IDLE;
            rStep   <= '0;
            rMode   <= '0;
            rPulse0 <= 1'b0;
            rPulse1 <= 1'b0;
            oLed    <= '0;
            oEdge   <= 1'b0;
            oBusy   <= 1'b0;
            oDone   <= 1'b0;
        end else begin
            rPulse0 <= iPulse;
            rPulse1 <= rPulse0;
            oEdge   <= 1'b0;
            oDone   <= 1'b0;

            case (rState)
                IDLE: begin
                    if (iStart && !iStop) begin
                        rState <= RUN;
                        rStep  <= '0;
                        rMode  <= iMode;
                        oLed   <= ledPattern(iMode, 8'd0);
                        oBusy  <= 1'b1;
                    end
                end

                RUN: begin
                    // Stop takes priority, including over the final edge, so
                    // an aborted sequence never reports completion.
                    if (iStop) begin
                        rState <= IDLE;
                        rStep  <= '0;
                        oLed   <= '0;
                        oBusy  <= 1'b0;
                    end else if (qualEdge) begin
                        oEdge <= 1'b1;
                        if (rStep == cLastStep) begin
                            oDone <= 1'b1;
                            rStep <= '0;
                            if (pLoop) begin
                                oLed <= ledPattern(rMode, 8'd0);
                            end else begin
                                rState <= IDLE;
                                oLed   <= '0;
                                oBusy  <= 1'b0;
                            end
                        end else begin
                            rStep <= rStep + 8'd1;
                            oLed  <= ledPattern(rMode, rStep + 8'd1);
                        end
                    end
                end

                default: rState <= IDLE;
            endcase
        end
    end

endmodule
